// File: rtl/line_option_fifo.sv
// Circular queue of pending line-solve jobs in front of the solver.
// Requeues take priority over loads; tracks a no-progress pass.
module line_option_fifo #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_row,
  input  logic [SIZE-1:0]          in_line,
  input  logic [SIZE-1:0]          in_option,
  input  logic [SIZE:0]            in_option_num,
  input  logic                     rq_valid,
  input  logic                     rq_row,
  input  logic [SIZE-1:0]          rq_line,
  input  logic [SIZE-1:0]          rq_option,
  input  logic [SIZE:0]            rq_option_num,
  input  logic                     ret_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_row,
  output logic [SIZE-1:0]          out_line,
  output logic [SIZE-1:0]          out_option,
  output logic [SIZE:0]            out_option_num,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     stuck,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3*SIZE + 2;
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   streak;
  logic [EW-1:0] wr_data;
  logic          full;
  logic          pop;
  logic          rq_acc;
  logic          ld_acc;
  logic          wr;

  assign full      = (count == FULL);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = !rq_valid && !full;
  assign ld_acc    = in_valid && in_ready;
  // A full queue can still take a requeue when the head leaves this cycle
  assign rq_acc    = rq_valid && (!full || pop);
  assign wr        = rq_acc || ld_acc;
  assign stuck     = out_valid && (streak >= count);

  assign wr_data = rq_valid
    ? {rq_row, rq_line, rq_option, rq_option_num}
    : {in_row, in_line, in_option, in_option_num};

  assign {out_row, out_line, out_option, out_option_num} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      streak   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (wr && !pop)
        count <= count + CNT_ONE;
      else if (!wr && pop)
        count <= count - CNT_ONE;
      if (rq_valid && !rq_acc)
        overflow <= 1'b1;
      if (ret_valid || ld_acc)
        streak <= '0;
      else if (rq_acc && (streak != FULL))
        streak <= streak + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_line_option_fifo.sv
// Bench for line_option_fifo: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_line_option_fifo;

  localparam int SIZE  = 4;
  localparam int DEPTH = 16;
  localparam int EW    = 3*SIZE + 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid, in_ready;
  logic            in_row;
  logic [SIZE-1:0] in_line, in_option;
  logic [SIZE:0]   in_option_num;
  logic            rq_valid, rq_row;
  logic [SIZE-1:0] rq_line, rq_option;
  logic [SIZE:0]   rq_option_num;
  logic            ret_valid;
  logic            out_valid, out_ready, out_row;
  logic [SIZE-1:0] out_line, out_option;
  logic [SIZE:0]   out_option_num;
  logic [CW-1:0]   count;
  logic            stuck, overflow;

  logic [EW-1:0] in_e, rq_e, out_e;
  assign {in_row, in_line, in_option, in_option_num} = in_e;
  assign {rq_row, rq_line, rq_option, rq_option_num} = rq_e;
  assign out_e = {out_row, out_line, out_option, out_option_num};

  line_option_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_line(in_line),
    .in_option(in_option), .in_option_num(in_option_num),
    .rq_valid(rq_valid), .rq_row(rq_row), .rq_line(rq_line),
    .rq_option(rq_option), .rq_option_num(rq_option_num),
    .ret_valid(ret_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_line(out_line),
    .out_option(out_option), .out_option_num(out_option_num),
    .count(count), .stuck(stuck), .overflow(overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: job queue, progress streak, sticky drop flag
  logic [EW-1:0] mq[$];
  int m_streak;
  bit m_ovf;

  function automatic logic [EW-1:0] rnd_e();
    return EW'($urandom);
  endfunction

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; rq_valid = 1'b0;
    out_ready = 1'b0; ret_valid = 1'b0;
  endtask

  task automatic tick();
    int sz;
    bit p, rq_ok, ld_ok;
    if (rst) begin
      mq.delete();
      m_streak = 0;
      m_ovf = 1'b0;
    end else begin
      sz = mq.size();
      p = (sz != 0) && out_ready;
      rq_ok = rq_valid && ((sz < DEPTH) || p);
      ld_ok = in_valid && !rq_valid && (sz < DEPTH);
      if (rq_valid && !rq_ok) m_ovf = 1'b1;
      if (p) void'(mq.pop_front());
      if (rq_ok) mq.push_back(rq_e);
      else if (ld_ok) mq.push_back(in_e);
      if (ret_valid || ld_ok) m_streak = 0;
      else if (rq_ok && m_streak < DEPTH) m_streak++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (count !== 0) begin
      n_errors++; $display("FAIL rst_count got %0d exp 0", count);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid);
    end
    n_checks++;
    if (stuck !== 1'b0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_flags got stuck=%b ovf=%b exp 0 0", stuck, overflow);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready);
    end
    rq_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL rst_in_ready_rq got %b exp 0", in_ready);
    end
    rq_valid = 1'b0;
  endtask

  task automatic test_order();
    logic [EW-1:0] e[3];
    for (int i = 0; i < 3; i++)
      e[i] = {1'b1, SIZE'(i), SIZE'($urandom), (SIZE+1)'($urandom)};
    idle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_e = e[i];
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_e !== e[0]) begin
        n_errors++;
        $display("FAIL order_head%0d got v=%b %h exp 1 %h", i, out_valid, out_e, e[0]);
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3) begin
      n_errors++; $display("FAIL order_count got %0d exp 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (out_e !== e[i]) begin
        n_errors++; $display("FAIL order_pop%0d got %h exp %h", i, out_e, e[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL order_empty got %b exp 0", out_valid);
    end
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_e = rnd_e();
      tick();
    end
    n_checks++;
    if (count !== CW'(DEPTH) || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL full_state got cnt=%0d rdy=%b exp 16 0", count, in_ready);
    end
    in_valid = 1'b0;
    rq_valid = 1'b1;
    rq_e = rnd_e();
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (count !== CW'(DEPTH) || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL full_rq_pop got cnt=%0d ovf=%b exp 16 0", count, overflow);
    end
    out_ready = 1'b0;
    rq_e = rnd_e();
    tick();
    n_checks++;
    if (count !== CW'(DEPTH) || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL full_drop got cnt=%0d ovf=%b exp 16 1", count, overflow);
    end
    rq_valid = 1'b0;
    tick();
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++; $display("FAIL ovf_sticky got %b exp 1", overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 4 && mq.size() > 0; i++) begin
      n_checks++;
      if (out_e !== mq[0]) begin
        n_errors++; $display("FAIL full_drain%0d got %h exp %h", i, out_e, mq[0]);
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL full_empty got v=%b ovf=%b exp 0 1", out_valid, overflow);
    end
  endtask

  task automatic test_priority();
    logic [EW-1:0] x[4];
    idle();
    for (int i = 0; i < 4; i++) x[i] = rnd_e();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_e = x[i];
      tick();
    end
    in_e = x[3];
    rq_valid = 1'b1;
    rq_e = x[2];
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL prio_ready got %b exp 0", in_ready);
    end
    tick();
    n_checks++;
    if (count !== 3) begin
      n_errors++; $display("FAIL prio_count got %0d exp 3", count);
    end
    rq_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL prio_ready2 got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 4) begin
      n_errors++; $display("FAIL prio_count2 got %0d exp 4", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_e !== x[i]) begin
        n_errors++; $display("FAIL prio_order%0d got %h exp %h", i, out_e, x[i]);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] exp_q[$];
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 41; i++) begin
      in_valid = (i < 40);
      in_e = rnd_e();
      #1;
      n_checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        n_errors++;
        $display("FAIL b2b_valid%0d got %b exp %b", i, out_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        if (out_e !== exp_q[0]) begin
          n_errors++; $display("FAIL b2b_data%0d got %h exp %h", i, out_e, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (in_valid) exp_q.push_back(in_e);
      tick();
      n_checks++;
      if (count > 1) begin
        n_errors++; $display("FAIL b2b_count%0d got %0d exp <=1", i, count);
      end
    end
    idle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_empty got %b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_e = rnd_e();
      tick();
    end
    n_checks++;
    if (count !== 5 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_pre got cnt=%0d ovf=%b exp 5 1", count, overflow);
    end
    rst = 1'b1;
    rq_valid = 1'b1;
    rq_e = rnd_e();
    tick();
    idle();
    #1;
    n_checks++;
    if (count !== 0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_rst got cnt=%0d v=%b exp 0 0", count, out_valid);
    end
    n_checks++;
    if (overflow !== 1'b0 || stuck !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_flags got ovf=%b stuck=%b exp 0 0", overflow, stuck);
    end
  endtask

  task automatic test_stuck();
    idle();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_e = rnd_e();
      tick();
    end
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      out_ready = 1'b1;
      rq_valid = 1'b1;
      rq_e = mq[0];
      tick();
      n_checks++;
      if (stuck !== (k >= 4) || count !== 4) begin
        n_errors++;
        $display("FAIL stuck_k%0d got stuck=%b cnt=%0d exp %b 4", k, stuck, count, k >= 4);
      end
    end
    idle();
    ret_valid = 1'b1;
    tick();
    ret_valid = 1'b0;
    n_checks++;
    if (stuck !== 1'b0 || count !== 4) begin
      n_errors++;
      $display("FAIL stuck_clear got stuck=%b cnt=%0d exp 0 4", stuck, count);
    end
  endtask

  task automatic test_random();
    int sz;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(99) == 0);
      in_valid = $urandom_range(1);
      rq_valid = ($urandom_range(3) == 0);
      out_ready = (i < 200) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 1);
      ret_valid = ($urandom_range(7) == 0);
      in_e = rnd_e();
      rq_e = rnd_e();
      #1;
      sz = mq.size();
      n_checks++;
      if (in_ready !== (!rq_valid && sz < DEPTH)) begin
        n_errors++; $display("FAIL rnd_ready%0d got %b", i, in_ready);
      end
      n_checks++;
      if (count !== CW'(sz) || out_valid !== (sz != 0)) begin
        n_errors++;
        $display("FAIL rnd_count%0d got %0d v=%b exp %0d", i, count, out_valid, sz);
      end
      n_checks++;
      if (stuck !== (sz != 0 && m_streak >= sz)) begin
        n_errors++;
        $display("FAIL rnd_stuck%0d got %b exp %b", i, stuck, sz != 0 && m_streak >= sz);
      end
      n_checks++;
      if (overflow !== m_ovf) begin
        n_errors++; $display("FAIL rnd_ovf%0d got %b exp %b", i, overflow, m_ovf);
      end
      if (sz != 0) begin
        n_checks++;
        if (out_e !== mq[0]) begin
          n_errors++; $display("FAIL rnd_head%0d got %h exp %h", i, out_e, mq[0]);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    in_e = '0;
    rq_e = '0;
    m_streak = 0;
    m_ovf = 1'b0;
    test_reset();
    test_order();
    test_full();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_stuck();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/line_option_fifo.md
# line_option_fifo

Circular queue of pending line-solve jobs that sits directly upstream of the FIFO solver. Each entry holds one line's orientation, index, candidate option and remaining option count. Jobs come from the loader (initial fill) or are requeued by the solver when it cannot yet decide a line. The queue presents the head entry to the solver and tracks whether a full pass has gone by without progress.

## Interface
Parameters:
- SIZE, 4, board dimension; sets option width and line-index width.
- DEPTH, 16, entry capacity; power of two, at least 2*SIZE.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  loader offers an entry.
- in_ready  out  1  loader entry accepted this cycle when in_valid is also high.
- in_row  in  1  1 = row, 0 = column.
- in_line  in  SIZE  line index.
- in_option  in  SIZE  candidate option bits.
- in_option_num  in  SIZE+1  remaining option count.
- rq_valid  in  1  solver requeue strobe (put back to FIFO).
- rq_row, rq_line, rq_option, rq_option_num  in  1/SIZE/SIZE/SIZE+1  requeued entry fields.
- ret_valid  in  1  solver retired a popped entry with progress (not requeued).
- out_valid  out  1  head entry present.
- out_ready  in  1  solver takes the head.
- out_row, out_line, out_option, out_option_num  out  1/SIZE/SIZE/SIZE+1  head entry fields.
- count  out  $clog2(DEPTH)+1  occupancy.
- stuck  out  1  one full pass of requeues with no progress.
- overflow  out  1  sticky; a requeue was dropped.

## Operation
- Storage: DEPTH-entry register array, head pointer wr_ptr/rd_ptr of $clog2(DEPTH) bits; both wrap modulo DEPTH.
- Pop: fires when out_valid && out_ready. rd_ptr advances by 1 and count decrements.
- Write sources are prioritised, with at most one write per cycle:
  - Requeue has priority. It is accepted if count < DEPTH, or if count == DEPTH and a pop fires in the same cycle.
  - If the queue is full and no pop fires, the requeue is dropped and overflow is set. overflow clears only on rst.
  - Load: in_ready = !rq_valid && (count < DEPTH). A load is never accepted while full, even with a simultaneous pop.
- Simultaneous accepted write and pop: count is unchanged, and both pointers advance.
- Progress tracking:
  - streak counter has the same width as count and saturates at DEPTH.
  - streak increments on each accepted requeue.
  - streak clears on ret_valid or on an accepted load. If ret_valid and a requeue occur in the same cycle, clear wins.
  - stuck = (count != 0) && (streak >= count). It is combinational from registers.
- Field widths are stored and returned unmodified; the block does no arithmetic on option_num.

## Timing
- Reset values: wr_ptr = rd_ptr = 0, count = 0, streak = 0, overflow = 0. Therefore out_valid = 0, stuck = 0, in_ready = !rq_valid.
- out_* fields are undefined while out_valid = 0. Storage is not cleared by reset.
- Write-to-read latency: an entry written in cycle N is visible on out_* at cycle N+1 when the queue was empty. There is no same-cycle bypass.
- out_* is a combinational read of the head register; it is stable until a pop.
- rst asserted mid-operation discards all entries at the next edge. Inputs in that cycle are ignored.
- Wrap-around: after DEPTH writes, wr_ptr returns to 0. FIFO order is preserved across the wrap.

## Test plan
- Reset then load A, B, C (rows 0, 1, 2) with out_ready = 0 -> count = 3. out_* show A from the cycle after A's write. Pop three times -> A, B, C in order, then out_valid = 0.
- Fill to DEPTH = 16 -> in_ready = 0 and count = 16. Assert rq_valid with out_ready = 1 in the same cycle -> the requeue is accepted and count stays at 16. Assert rq_valid with out_ready = 0 -> it is dropped and overflow = 1 and stays 1.
- Assert in_valid and rq_valid together at count = 2 -> in_ready = 0 and only the requeue is written, so count = 3. Next cycle the load is accepted.
- Load 4 entries, then pop and requeue each unchanged 4 times -> stuck rises when streak reaches 4. One ret_valid pulse -> streak = 0 and stuck = 0.
- Write and pop continuously for 40 entries -> pointers wrap twice, order is intact, and count never exceeds 1.
- rst pulse with count = 5 -> next cycle count = 0, out_valid = 0, overflow = 0, stuck = 0.
